// File: rtl/spio_switch_drop_ctrl.sv
// Purpose : times how long the switch's selected outputs stay blocked and asks it to drop the head packet.
// Latency : stall sampled in cycle c -> waiting_o in c+1, drop_o in c+2+W; every output comes straight from a flop.
// Backpressure: drop_o stays high until the switch reports dropped_vld_i or the blockage clears.
//
// Ports:
//   clk_i, reset_i       rising-edge clock; asynchronous active-high reset
//   enable_i             0 forces IDLE; takes priority over every other transition
//   wait_cycles_i        blockage timeout W, sampled on entry to WAIT; all-ones never drops
//   blocked_outputs_i    switch blocked-outputs vector
//   selected_outputs_i   switch selected-outputs vector
//   dropped_vld_i        switch reports that a packet was dropped this cycle
//   drop_o               drop request to the switch (state DROP)
//   waiting_o            blockage is being timed (state WAIT)
//   clear_count_i        (SPIO_SWITCH_DROP_CTRL_STATS_EN only) zero the drop counter
//   drop_count_o         (SPIO_SWITCH_DROP_CTRL_STATS_EN only) saturating count of forced drops
//
// Optional feature: define SPIO_SWITCH_DROP_CTRL_STATS_EN to add the drop counter.

module spio_switch_drop_ctrl #(
    parameter int NUM_PORTS  = 4,
    parameter int TIMER_BITS = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [TIMER_BITS-1:0] wait_cycles_i,
    input  logic [NUM_PORTS-1:0]  blocked_outputs_i,
    input  logic [NUM_PORTS-1:0]  selected_outputs_i,
    input  logic                  dropped_vld_i,
`ifdef SPIO_SWITCH_DROP_CTRL_STATS_EN
    input  logic                  clear_count_i,
    output logic [15:0]           drop_count_o,
`endif
    output logic                  drop_o,
    output logic                  waiting_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam logic [TIMER_BITS-1:0] TIMER_ZERO = '0;
    localparam logic [TIMER_BITS-1:0] TIMER_ONE  = TIMER_BITS'(1);

    state_t                state_q, state_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    // Set when the timeout loaded on entry to WAIT was all-ones: the
    // blockage is then timed forever and never escalates to a drop.
    logic                  never_q, never_d;
    logic                  drop_q, waiting_q;
    logic                  stall;

    // A stall is a packet that wants an output the switch reports as blocked.
    assign stall = |(blocked_outputs_i & selected_outputs_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            timer_q   <= TIMER_ZERO;
            never_q   <= 1'b0;
            drop_q    <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            never_q   <= never_d;
            // Outputs are registered copies of the next state, so they always
            // equal the decode of state_q without any combinational path.
            drop_q    <= (state_d == ST_DROP);
            waiting_q <= (state_d == ST_WAIT);
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        never_d = never_q;

        if (!enable_i) begin
            state_d = ST_IDLE;
            timer_d = TIMER_ZERO;
            never_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = TIMER_ZERO;
                    never_d = 1'b0;
                    if (stall) begin
                        // The only point where wait_cycles_i is sampled.
                        state_d = ST_WAIT;
                        timer_d = wait_cycles_i;
                        never_d = &wait_cycles_i;
                    end
                end

                ST_WAIT: begin
                    if (!stall) begin
                        state_d = ST_IDLE;
                        timer_d = TIMER_ZERO;
                        never_d = 1'b0;
                    end else if (never_q) begin
                        // Infinite timeout: hold the timer and keep waiting.
                        state_d = ST_WAIT;
                    end else if (timer_q == TIMER_ZERO) begin
                        state_d = ST_DROP;
                    end else begin
                        timer_d = timer_q - TIMER_ONE;
                    end
                end

                ST_DROP: begin
                    timer_d = TIMER_ZERO;
                    never_d = 1'b0;
                    // Leave once the switch has dropped the packet, or if the
                    // blockage cleared on its own: nothing is left to drop.
                    if (dropped_vld_i || !stall) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    timer_d = TIMER_ZERO;
                    never_d = 1'b0;
                end
            endcase
        end
    end

    assign drop_o    = drop_q;
    assign waiting_o = waiting_q;

`ifdef SPIO_SWITCH_DROP_CTRL_STATS_EN
    logic [15:0] drop_cnt_q;

    // Counts drops this controller forced; the switch's own drops of
    // destination-less packets happen outside DROP and are not counted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_cnt_q <= 16'h0000;
        end else if (clear_count_i) begin
            drop_cnt_q <= 16'h0000;
        end else if ((state_q == ST_DROP) && dropped_vld_i && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'h0001;
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

endmodule
